// File: rtl/shifter_arbiter.sv
// Two-port arbiter sharing one external shift/rotate unit.
// Grants combinationally, returns registered results with a done pulse.
module shifter_arbiter #(
   parameter int WIDTH      = 16,
   parameter int CNT_W      = 4,
   parameter int FIXED_PRIO = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_req,
   input  logic [WIDTH-1:0] a_in,
   input  logic [CNT_W-1:0] a_cnt,
   input  logic [1:0]       a_op,
   output logic             a_gnt,
   output logic             a_done,
   output logic [WIDTH-1:0] a_out,
   input  logic             b_req,
   input  logic [WIDTH-1:0] b_in,
   input  logic [CNT_W-1:0] b_cnt,
   input  logic [1:0]       b_op,
   output logic             b_gnt,
   output logic             b_done,
   output logic [WIDTH-1:0] b_out,
   output logic [WIDTH-1:0] sh_in,
   output logic [CNT_W-1:0] sh_cnt,
   output logic [1:0]       sh_op,
   input  logic [WIDTH-1:0] sh_out
);

   localparam logic SIDE_A = 1'b0;
   localparam logic SIDE_B = 1'b1;
   localparam logic FIXED  = (FIXED_PRIO != 0);

   logic last_winner;
   logic a_win;
   logic b_win;

   // A wins when alone, under fixed priority, or when B won last
   always_comb begin
      a_win = a_req & (~b_req | FIXED | (last_winner == SIDE_B));
      b_win = b_req & ~a_win;
      a_gnt = rst & a_win;
      b_gnt = rst & b_win;
   end

   // Route the winner's operation to the shared unit, zeros when idle
   always_comb begin
      sh_in  = '0;
      sh_cnt = '0;
      sh_op  = '0;
      unique case (1'b1)
         a_gnt: begin
            sh_in  = a_in;
            sh_cnt = a_cnt;
            sh_op  = a_op;
         end
         b_gnt: begin
            sh_in  = b_in;
            sh_cnt = b_cnt;
            sh_op  = b_op;
         end
         default: begin
            sh_in  = '0;
            sh_cnt = '0;
            sh_op  = '0;
         end
      endcase
   end

   // Capture result for the winner, pulse done, track round-robin state
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_out       <= '0;
         b_out       <= '0;
         a_done      <= 1'b0;
         b_done      <= 1'b0;
         last_winner <= SIDE_B;
      end else begin
         a_done <= a_gnt;
         b_done <= b_gnt;
         if (a_gnt) a_out <= sh_out;
         if (b_gnt) b_out <= sh_out;
         if (a_gnt | b_gnt) last_winner <= b_gnt ? SIDE_B : SIDE_A;
      end
   end

endmodule
